// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing one dcache request port between NUM_REQ requesters,
// with in-order load response routing through an ID FIFO and a drain-then-flush sequencer.
module dcache_req_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = 56,
   parameter int DATA_W    = 64,
   parameter int MAX_OUTST = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ-1:0]            req_we_i,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
   input  logic [NUM_REQ*DATA_W/8-1:0]   req_be_i,
   output logic [NUM_REQ-1:0]            req_gnt_o,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   output logic [DATA_W-1:0]             rsp_rdata_o,
   output logic                          dc_req_o,
   output logic                          dc_we_o,
   output logic [ADDR_W-1:0]             dc_addr_o,
   output logic [DATA_W-1:0]             dc_wdata_o,
   output logic [DATA_W/8-1:0]           dc_be_o,
   input  logic                          dc_gnt_i,
   input  logic                          dc_rvalid_i,
   input  logic [DATA_W-1:0]             dc_rdata_i,
   input  logic                          flush_i,
   output logic                          flush_ack_o,
   output logic                          cache_flush_o,
   input  logic                          cache_flush_ack_i,
   output logic                          busy_o,
   output logic                          err_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int BE_W  = DATA_W / 8;

   typedef enum logic [1:0] {ARB, HOLD, DRAIN, FLUSH} state_t;

   state_t             state_reg;
   logic [IDX_W-1:0]   ptr_reg;
   logic [IDX_W-1:0]   lock_reg;
   logic [IDX_W-1:0]   id_mem [MAX_OUTST];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [PTR_W:0]     count_reg;
   logic               err_reg;

   logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
   logic [BE_W-1:0]    be_arr    [NUM_REQ];

   logic               in_hold;
   logic               grant;
   logic               push;
   logic               pop;
   logic               fifo_empty;
   logic               fifo_full;
   logic [IDX_W-1:0]   fifo_head;
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   cand;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign addr_arr[gi]    = req_addr_i[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi]   = req_wdata_i[gi*DATA_W +: DATA_W];
         assign be_arr[gi]      = req_be_i[gi*BE_W +: BE_W];
         assign req_gnt_o[gi]   = grant && (lock_reg == IDX_W'(gi));
         assign rsp_valid_o[gi] = pop && (fifo_head == IDX_W'(gi));
      end
   endgenerate

   function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
      int s;
      s = base + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDX_W'(s);
   endfunction

   assign in_hold    = (state_reg == HOLD);
   assign grant      = in_hold && dc_gnt_i;
   assign push       = grant && !req_we_i[lock_reg];
   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == (PTR_W+1)'(MAX_OUTST));
   assign pop        = dc_rvalid_i && !fifo_empty;
   assign fifo_head  = id_mem[rd_ptr_reg];

   // Search starts just after the last winner; reads are skipped while the ID FIFO is full.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = wrap_idx(int'(ptr_reg), i);
         if (!win_found && req_valid_i[cand] && (req_we_i[cand] || !fifo_full)) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) id_mem[wr_ptr_reg] <= lock_reg;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg  <= ARB;
         ptr_reg    <= IDX_W'(NUM_REQ - 1);
         lock_reg   <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         err_reg    <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (push && !pop)      count_reg <= count_reg + (PTR_W+1)'(1);
         else if (pop && !push) count_reg <= count_reg - (PTR_W+1)'(1);
         if (dc_rvalid_i && fifo_empty) err_reg <= 1'b1;

         case (state_reg)
            ARB: begin
               if (flush_i) begin
                  state_reg <= DRAIN;
               end else if (win_found) begin
                  lock_reg  <= win_idx;
                  ptr_reg   <= win_idx;
                  state_reg <= HOLD;
               end
            end
            HOLD: begin
               if (dc_gnt_i) state_reg <= ARB;
            end
            DRAIN: begin
               // Nothing can push here, so the last pop empties the FIFO.
               if (fifo_empty || (count_reg == (PTR_W+1)'(1) && pop)) state_reg <= FLUSH;
            end
            FLUSH: begin
               if (cache_flush_ack_i) state_reg <= ARB;
            end
            default: state_reg <= ARB;
         endcase
      end
   end

   assign dc_req_o      = in_hold;
   assign dc_we_o       = in_hold && req_we_i[lock_reg];
   assign dc_addr_o     = in_hold ? addr_arr[lock_reg]  : '0;
   assign dc_wdata_o    = in_hold ? wdata_arr[lock_reg] : '0;
   assign dc_be_o       = in_hold ? be_arr[lock_reg]    : '0;
   assign rsp_rdata_o   = pop ? dc_rdata_i : '0;
   assign cache_flush_o = (state_reg == FLUSH);
   assign flush_ack_o   = (state_reg == FLUSH) && cache_flush_ack_i;
   assign busy_o        = (state_reg != ARB) || !fifo_empty;
   assign err_o         = err_reg;

endmodule
